// File: rtl/router_input_buffer_if.sv
// Purpose: link-side and switch-side signals of one router input port.
// Latency: none (wiring only).
// Backpressure: credit_o throttles the link side, valid/ready the switch side.
interface router_input_buffer_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                    rx;
  logic [FLIT_WIDTH-1:0]   data_i;
  logic                    credit_o;
  logic                    valid_o;
  logic [FLIT_WIDTH-1:0]   data_o;
  logic                    sop_o;
  logic                    eop_o;
  logic                    ready_i;
  logic                    overflow_o;
  logic [$clog2(DEPTH):0]  occupancy_o;

  // Driver of the link and consumer of the buffered flits.
  modport master (
    output rx, data_i, ready_i,
    input  credit_o, valid_o, data_o, sop_o, eop_o, overflow_o, occupancy_o
  );

  // The input buffer itself.
  modport slave (
    input  rx, data_i, ready_i,
    output credit_o, valid_o, data_o, sop_o, eop_o, overflow_o, occupancy_o
  );
endinterface

// File: rtl/router_input_buffer.sv
// Purpose: credit-returning input FIFO for one router port, tags flits with sop/eop.
// Latency: a flit written on edge N is visible on data_o in cycle N+1 (no bypass).
// Backpressure: credit_o drops when full; flits arriving without credit are dropped and flagged.
module router_input_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  router_input_buffer_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_SIZE    = 2'd1,
    ST_PAYLOAD = 2'd2
  } frame_state_t;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  credit;
  logic                  valid;
  logic                  push;
  logic                  pop;
  logic                  overflow;
  logic [FLIT_WIDTH-1:0] head;

  frame_state_t          state;
  frame_state_t          state_nxt;
  logic [FLIT_WIDTH-1:0] rem;
  logic [FLIT_WIDTH-1:0] rem_nxt;
  logic                  sop_raw;
  logic                  eop_raw;

  // Credit and valid come straight from the registered count; both are forced
  // low while reset is asserted because count is only cleared at the edge.
  assign full   = (count == CNT_W'(DEPTH));
  assign credit = !reset && !full;
  assign valid  = !reset && (count != '0);
  assign head   = mem[rd_ptr];
  assign push   = bus.rx && credit;
  assign pop    = valid && bus.ready_i;

  assign bus.credit_o    = credit;
  assign bus.valid_o     = valid;
  assign bus.data_o      = head;
  assign bus.sop_o       = valid && sop_raw;
  assign bus.eop_o       = valid && eop_raw;
  assign bus.overflow_o  = overflow;
  assign bus.occupancy_o = count;

  // Flit storage; contents need no reset since valid_o masks stale entries.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.rx && !credit) begin
        overflow <= 1'b1;
      end
    end
  end

  // Framing state register; reset always lands on a packet boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_HEADER;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Framing next-state and sop/eop decode; only a pop advances the framing.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sop_raw   = 1'b0;
    eop_raw   = 1'b0;
    case (state)
      ST_HEADER: begin
        sop_raw = 1'b1;
        if (pop) begin
          state_nxt = ST_SIZE;
        end
      end
      ST_SIZE: begin
        // A zero size flit closes the packet itself.
        eop_raw = (head == '0);
        if (pop) begin
          rem_nxt   = head;
          state_nxt = (head == '0) ? ST_HEADER : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        eop_raw = (rem == FLIT_WIDTH'(1));
        if (pop) begin
          rem_nxt = rem - FLIT_WIDTH'(1);
          if (rem == FLIT_WIDTH'(1)) begin
            state_nxt = ST_HEADER;
          end
        end
      end
      default: begin
        state_nxt = ST_HEADER;
      end
    endcase
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed vector table plus hand-written
// sequences for reset, overflow, pointer wrap and mid-packet reset.
module tb_router_input_buffer;

  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int NV    = 21;
  localparam int NS    = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  router_input_buffer_if #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) bus ();

  router_input_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          rx;
    logic [FW-1:0] d;
    logic          rdy;
    logic          credit;
    logic          valid;
    logic [FW-1:0] dat;
    logic          sop;
    logic          eop;
    logic [OW-1:0] occ;
    logic          ovf;
  } vec_t;

  vec_t          vt [NV];
  logic [FW-1:0] stream [NS];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic vec_t mk(input int rx, input int d, input int rdy,
                              input int credit, input int valid, input int dat,
                              input int sop, input int eop, input int occ, input int ovf);
    vec_t v;
    v.rx     = 1'(rx);
    v.d      = FW'(d);
    v.rdy    = 1'(rdy);
    v.credit = 1'(credit);
    v.valid  = 1'(valid);
    v.dat    = FW'(dat);
    v.sop    = 1'(sop);
    v.eop    = 1'(eop);
    v.occ    = OW'(occ);
    v.ovf    = 1'(ovf);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // rx d rdy | credit valid dat sop eop occ ovf   (state after the edge)
    // Packet 0x0101, size 3, A B C with ready held high.
    vt[0]  = mk(1, 'h0101, 1,  1, 1, 'h0101, 1, 0, 1, 0);
    vt[1]  = mk(1, 'h0003, 1,  1, 1, 'h0003, 0, 0, 1, 0);
    vt[2]  = mk(1, 'h000A, 1,  1, 1, 'h000A, 0, 0, 1, 0);
    vt[3]  = mk(1, 'h000B, 1,  1, 1, 'h000B, 0, 0, 1, 0);
    vt[4]  = mk(1, 'h000C, 1,  1, 1, 'h000C, 0, 1, 1, 0);
    vt[5]  = mk(0, 'h0000, 1,  1, 0, 'h0000, 0, 0, 0, 0);
    // Zero-size packet followed back-to-back by another header, then size-1 packet.
    vt[6]  = mk(1, 'h0202, 1,  1, 1, 'h0202, 1, 0, 1, 0);
    vt[7]  = mk(1, 'h0000, 1,  1, 1, 'h0000, 0, 1, 1, 0);
    vt[8]  = mk(1, 'h0303, 1,  1, 1, 'h0303, 1, 0, 1, 0);
    vt[9]  = mk(1, 'h0001, 1,  1, 1, 'h0001, 0, 0, 1, 0);
    vt[10] = mk(1, 'h000D, 1,  1, 1, 'h000D, 0, 1, 1, 0);
    vt[11] = mk(0, 'h0000, 1,  1, 0, 'h0000, 0, 0, 0, 0);
    // Fill with ready low, then overflow while full.
    vt[12] = mk(1, 'h00E0, 0,  1, 1, 'h00E0, 1, 0, 1, 0);
    vt[13] = mk(1, 'h00E1, 0,  1, 1, 'h00E0, 1, 0, 2, 0);
    vt[14] = mk(1, 'h00E2, 0,  1, 1, 'h00E0, 1, 0, 3, 0);
    vt[15] = mk(1, 'h00E3, 0,  0, 1, 'h00E0, 1, 0, 4, 0);
    vt[16] = mk(1, 'h0BAD, 0,  0, 1, 'h00E0, 1, 0, 4, 1);
    // Full with rx and pop together: pop happens, rx dropped, credit returns.
    vt[17] = mk(1, 'h0BAE, 1,  1, 1, 'h00E1, 0, 0, 3, 1);
    vt[18] = mk(0, 'h0000, 1,  1, 1, 'h00E2, 0, 0, 2, 1);
    vt[19] = mk(0, 'h0000, 1,  1, 1, 'h00E3, 0, 0, 1, 1);
    vt[20] = mk(0, 'h0000, 1,  1, 0, 'h0000, 0, 0, 0, 1);

    // Stream of five packets: header, size 2, two payload flits.
    for (int i = 0; i < NS; i++) begin
      if (i % 4 == 0)      stream[i] = FW'(32'h0100 + i);
      else if (i % 4 == 1) stream[i] = FW'(2);
      else                 stream[i] = FW'(32'hC000 + i);
    end

    bus.rx      = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;

    // Reset held for three cycles.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_credit", bus.credit_o, 0);
      chk("rst_valid", bus.valid_o, 0);
    end
    reset = 1'b0;
    step();
    chk("post_rst_credit", bus.credit_o, 1);
    chk("post_rst_valid", bus.valid_o, 0);
    chk("post_rst_occ", bus.occupancy_o, 0);
    chk("post_rst_ovf", bus.overflow_o, 0);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      bus.rx      = vt[i].rx;
      bus.data_i  = vt[i].d;
      bus.ready_i = vt[i].rdy;
      step();
      chk($sformatf("v%0d_credit", i), bus.credit_o, vt[i].credit);
      chk($sformatf("v%0d_valid", i), bus.valid_o, vt[i].valid);
      if (vt[i].valid) begin
        chk($sformatf("v%0d_data", i), bus.data_o, vt[i].dat);
      end
      chk($sformatf("v%0d_sop", i), bus.sop_o, vt[i].sop);
      chk($sformatf("v%0d_eop", i), bus.eop_o, vt[i].eop);
      chk($sformatf("v%0d_occ", i), bus.occupancy_o, vt[i].occ);
      chk($sformatf("v%0d_ovf", i), bus.overflow_o, vt[i].ovf);
    end

    // Clear overflow and the leftover framing state before streaming.
    bus.rx      = 1'b0;
    bus.ready_i = 1'b0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_ovf", bus.overflow_o, 0);
    chk("rst2_occ", bus.occupancy_o, 0);

    // Pointer-wrap stream with random ready and credit-gated rx.
    begin
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      while (got < NS && cyc < 1000) begin
        logic r;
        r = 1'($urandom_range(0, 1));
        bus.ready_i = r;
        if (bus.valid_o && r) begin
          chk($sformatf("s%0d_data", got), bus.data_o, stream[got]);
          chk($sformatf("s%0d_sop", got), bus.sop_o, (got % 4) == 0);
          chk($sformatf("s%0d_eop", got), bus.eop_o, (got % 4) == 3);
          got++;
        end
        if (bus.credit_o && sent < NS) begin
          bus.rx     = 1'b1;
          bus.data_i = stream[sent];
          sent++;
        end else begin
          bus.rx = 1'b0;
        end
        step();
        cyc++;
      end
      bus.rx      = 1'b0;
      bus.ready_i = 1'b0;
      chk("stream_received", got, NS);
      chk("stream_ovf", bus.overflow_o, 0);
    end

    // Reset in the middle of a payload.
    bus.rx = 1'b1;
    bus.data_i = 'h0A00; step();
    bus.data_i = 'h0005; step();
    bus.data_i = 'h0011; step();
    bus.data_i = 'h0022; step();
    bus.rx      = 1'b0;
    bus.ready_i = 1'b1;
    step();
    step();
    bus.ready_i = 1'b0;
    chk("mid_data", bus.data_o, 'h0011);
    chk("mid_sop", bus.sop_o, 0);
    chk("mid_occ", bus.occupancy_o, 2);
    reset = 1'b1;
    step();
    chk("midrst_valid", bus.valid_o, 0);
    chk("midrst_credit", bus.credit_o, 0);
    reset = 1'b0;
    step();
    chk("after_midrst_occ", bus.occupancy_o, 0);
    chk("after_midrst_valid", bus.valid_o, 0);
    chk("after_midrst_credit", bus.credit_o, 1);
    bus.rx     = 1'b1;
    bus.data_i = 'h0B00;
    step();
    bus.rx = 1'b0;
    chk("new_hdr_data", bus.data_o, 'h0B00);
    chk("new_hdr_sop", bus.sop_o, 1);
    chk("new_hdr_eop", bus.eop_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
